// File: rtl/pkt_tuple_extractor.sv
// IPv4 5-tuple extractor: parses a 32-bit word stream and queues {src,dst,proto,ports} in a small FIFO.
// Optional header checksum verification is enabled with `define HDR_CSUM_EN.
module pkt_tuple_extractor #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             tuple_valid,
    input  logic             tuple_ready,
    output logic [71:0]      ip_protocol,
    output logic [15:0]      src_port,
    output logic [15:0]      dst_port,
    output logic [CNT_W-1:0] drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 104;

    typedef enum logic [2:0] {W0, HDR, OPTS, L4, DRAIN} state_t;

    state_t      r_state, w_nxt;
    logic [3:0]  r_wi, r_ihl;
    logic [7:0]  r_proto;
    logic [31:0] r_src, r_dst;
    logic [AW:0] r_wptr, r_rptr;
    logic [EW-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_drop;

    logic w_acc, w_full, w_empty, w_pop, w_push, w_drop;
    logic w_l4proto, w_last_hdr, w_on_push, w_csum_ok;
    logic [31:0] w_dst, w_ports;
    logic [EW-1:0] w_entry;

    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_pop   = !w_empty && tuple_ready;

    assign w_l4proto  = (r_proto == 8'd6) || (r_proto == 8'd17);
    assign w_last_hdr = (r_state == HDR && r_wi == 4'd4 && r_ihl == 4'd5) ||
                        (r_state == OPTS && r_wi == r_ihl - 4'd1);
    // Push position depends only on registered state, so the stall never looks at s_data
    assign w_on_push  = (w_last_hdr && !w_l4proto) || (r_state == L4);
    assign s_ready    = !(w_on_push && w_full);
    assign w_acc      = s_valid && s_ready;

`ifdef HDR_CSUM_EN
    logic [15:0] r_csum, w_csum_base, w_csum_nxt;

    function automatic logic [15:0] f_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    assign w_csum_base = (r_state == W0) ? 16'd0 : r_csum;
    assign w_csum_nxt  = f_add(f_add(w_csum_base, s_data[31:16]), s_data[15:0]);
    assign w_csum_ok   = (w_csum_nxt == 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_csum <= '0;
        else if (w_acc && (r_state == W0 || r_state == HDR || r_state == OPTS))
            r_csum <= w_csum_nxt;
    end
`else
    assign w_csum_ok = 1'b1;
`endif

    // dst_ip arrives on the push word itself when IHL=5 and there is no L4 header
    assign w_dst   = (r_state == HDR) ? s_data : r_dst;
    assign w_ports = (r_state == L4) ? s_data : 32'd0;
    assign w_entry = {r_src, w_dst, r_proto, w_ports};

    always_comb begin
        w_nxt  = r_state;
        w_push = 1'b0;
        w_drop = 1'b0;
        if (w_acc) begin
            case (r_state)
                W0: begin
                    if (s_data[31:28] != 4'd4 || s_data[27:24] < 4'd5) begin
                        w_drop = 1'b1;
                        w_nxt  = s_last ? W0 : DRAIN;
                    end else if (s_last) begin
                        w_drop = 1'b1;
                        w_nxt  = W0;
                    end else begin
                        w_nxt = HDR;
                    end
                end
                HDR, OPTS: begin
                    if (w_last_hdr) begin
                        if (!w_csum_ok) begin
                            w_drop = 1'b1;
                            w_nxt  = s_last ? W0 : DRAIN;
                        end else if (w_l4proto) begin
                            w_drop = s_last;
                            w_nxt  = s_last ? W0 : L4;
                        end else begin
                            w_push = 1'b1;
                            w_nxt  = s_last ? W0 : DRAIN;
                        end
                    end else if (s_last) begin
                        w_drop = 1'b1;
                        w_nxt  = W0;
                    end else if (r_state == HDR && r_wi == 4'd4) begin
                        w_nxt = OPTS;
                    end
                end
                L4: begin
                    w_push = 1'b1;
                    w_nxt  = s_last ? W0 : DRAIN;
                end
                DRAIN: begin
                    if (s_last) w_nxt = W0;
                end
                default: w_nxt = W0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= W0;
            r_wi    <= '0;
            r_ihl   <= '0;
            r_proto <= '0;
            r_src   <= '0;
            r_dst   <= '0;
        end else begin
            r_state <= w_nxt;
            if (w_acc) begin
                if (r_state == W0) begin
                    r_wi  <= 4'd1;
                    r_ihl <= s_data[27:24];
                end else if (r_state == HDR || r_state == OPTS) begin
                    r_wi <= r_wi + 4'd1;
                end
                if (r_state == HDR) begin
                    if (r_wi == 4'd2) r_proto <= s_data[23:16];
                    if (r_wi == 4'd3) r_src   <= s_data;
                    if (r_wi == 4'd4) r_dst   <= s_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[AW-1:0]] <= w_entry;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_drop <= '0;
        else if (w_drop && !(&r_drop))
            r_drop <= r_drop + 1'b1;
    end

    assign tuple_valid = !w_empty;
    assign {ip_protocol, src_port, dst_port} = r_mem[r_rptr[AW-1:0]];
    assign drop_count = r_drop;
endmodule

// File: tb/tb_pkt_tuple_extractor.sv
// Scoreboard bench for pkt_tuple_extractor; checksum-specific cases run when HDR_CSUM_EN is defined.
module tb_pkt_tuple_extractor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready, tuple_valid;
    logic        tuple_ready = 1'b0;
    logic [71:0] ip_protocol;
    logic [15:0] src_port, dst_port, drop_count;

    int n_chk = 0;
    int n_err = 0;
    int exp_drop = 0;
    logic [103:0] sb[$];
    logic [31:0]  pkt[$];

    pkt_tuple_extractor #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .tuple_valid(tuple_valid), .tuple_ready(tuple_ready),
        .ip_protocol(ip_protocol), .src_port(src_port), .dst_port(dst_port),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Pops the scoreboard on every handshake seen mid-cycle
    always @(negedge clk) begin
        if (rst_n && tuple_valid && tuple_ready) begin
            if (sb.size() == 0) chk("unexpected_tuple", {ip_protocol, src_port, dst_port}, '0);
            else chk("tuple", {ip_protocol, src_port, dst_port}, sb.pop_front());
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    task automatic fix_csum();
        logic [15:0] s;
        int ihl;
        ihl = int'(pkt[0][27:24]);
        pkt[2][15:0] = 16'h0;
        s = 16'h0;
        for (int i = 0; i < ihl; i++) s = oc_add(oc_add(s, pkt[i][31:16]), pkt[i][15:0]);
        pkt[2][15:0] = ~s;
    endtask

    // Builds a packet and pushes its expected tuple
    task automatic mk(input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                      input logic [15:0] sp, input logic [15:0] dp, input int nopt);
        logic l4;
        l4 = (proto == 8'd6) || (proto == 8'd17);
        pkt.delete();
        pkt.push_back({4'h4, 4'(5 + nopt), 24'h000028});
        pkt.push_back(32'h0);
        pkt.push_back({8'h40, proto, 16'h0});
        pkt.push_back(src);
        pkt.push_back(dst);
        for (int i = 0; i < nopt; i++) pkt.push_back(32'h01010101);
        if (l4) pkt.push_back({sp, dp});
        fix_csum();
        sb.push_back({src, dst, proto, l4 ? sp : 16'h0, l4 ? dp : 16'h0});
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("s_ready_timeout", s_ready, 1'b1);
        sync();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_pkt();
        for (int i = 0; i < pkt.size(); i++) send_word(pkt[i], i == pkt.size() - 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        tuple_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            sync();
            n++;
        end
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #12;
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_tuple_valid", tuple_valid, 1'b0);
        chk("rst_fields", {ip_protocol, src_port, dst_port}, '0);
        chk("rst_drop", drop_count, 16'd0);
        rst_n = 1'b1;
        sync();

        // TCP IHL=5 with latency check
        tuple_ready = 1'b1;
        mk(8'h06, 32'hC0A80001, 32'h0A000002, 16'h1F90, 16'h0050, 0);
        for (int i = 0; i < 5; i++) send_word(pkt[i], 1'b0);
        @(negedge clk);
        chk("lat_before", tuple_valid, 1'b0);
        sync();
        send_word(pkt[5], 1'b1);
        @(negedge clk);
        chk("lat_after", tuple_valid, 1'b1);
        sync();
        wait_drain();
        chk("drop_tcp", drop_count, 16'(exp_drop));

        // ICMP IHL=6: push lands on the option word, trailing word drained
        mk(8'h01, 32'h11223344, 32'h55667788, 16'h0, 16'h0, 1);
        for (int i = 0; i < 6; i++) send_word(pkt[i], 1'b0);
        @(negedge clk);
        chk("icmp_push_on_opt", tuple_valid, 1'b1);
        sync();
        send_word(32'hDEADBEEF, 1'b1);
        wait_drain();

        // Malformed: version 6, IHL<5, truncation at wi=3
        send_word(32'h60000000, 1'b0);
        send_word(32'h0, 1'b0);
        send_word(32'h0, 1'b1);
        exp_drop++;
        repeat (2) sync();
        chk("drop_v6", drop_count, 16'(exp_drop));
        mk(8'h11, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'h1234, 16'h0035, 0);
        send_pkt();
        wait_drain();
        send_word(32'h44000000, 1'b0);
        send_word(32'h0, 1'b1);
        exp_drop++;
        mk(8'h06, 32'hC0A80001, 32'h0A000002, 16'h1F90, 16'h0050, 0);
        void'(sb.pop_back());
        for (int i = 0; i < 4; i++) send_word(pkt[i], i == 3);
        exp_drop++;
        sync();
        chk("drop_trunc", drop_count, 16'(exp_drop));
        chk("trunc_no_tuple", tuple_valid, 1'b0);

        // Backpressure: four buffered, fifth stalls on its L4 word
        tuple_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            mk(8'h06, 32'hAC100000 + p, 32'h0A000000 + p, 16'(16'h1000 + p), 16'(16'h2000 + p), 0);
            send_pkt();
        end
        mk(8'h06, 32'hAC100004, 32'h0A000004, 16'h1004, 16'h2004, 0);
        for (int i = 0; i < 5; i++) send_word(pkt[i], 1'b0);
        s_valid = 1'b1;
        s_data  = pkt[5];
        s_last  = 1'b1;
        @(negedge clk);
        chk("full_stall", s_ready, 1'b0);
        chk("full_valid", tuple_valid, 1'b1);
        sync();
        tuple_ready = 1'b1;
        @(negedge clk);
        chk("stall_during_pop", s_ready, 1'b0);
        sync();
        tuple_ready = 1'b0;
        @(negedge clk);
        chk("stall_released", s_ready, 1'b1);
        sync();
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_drain();

        // Reset mid-HDR with two tuples buffered
        tuple_ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            mk(8'h11, 32'h01010100 + p, 32'h02020200 + p, 16'h0007, 16'h0008, 0);
            send_pkt();
        end
        mk(8'h06, 32'h0, 32'h0, 16'h0, 16'h0, 0);
        send_word(pkt[0], 1'b0);
        send_word(pkt[1], 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        exp_drop = 0;
        #1;
        chk("mid_rst_valid", tuple_valid, 1'b0);
        chk("mid_rst_drop", drop_count, 16'd0);
        chk("mid_rst_ready", s_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        tuple_ready = 1'b1;
        mk(8'h06, 32'hC0A80101, 32'hC0A80202, 16'hABCD, 16'h01BB, 0);
        send_pkt();
        wait_drain();

`ifdef HDR_CSUM_EN
        pkt.delete();
        pkt = '{32'h4500003C, 32'h1C464000, 32'h4006B1E6, 32'hAC100A63, 32'hAC100A0C, 32'h04D20050};
        sb.push_back({32'hAC100A63, 32'hAC100A0C, 8'h06, 16'h04D2, 16'h0050});
        send_pkt();
        wait_drain();
        chk("csum_ok_drop", drop_count, 16'(exp_drop));
        pkt[2] = 32'h4006B1E7;
        send_pkt();
        exp_drop++;
        repeat (3) sync();
        chk("csum_bad_drop", drop_count, 16'(exp_drop));
        chk("csum_bad_no_tuple", tuple_valid, 1'b0);
`endif

        repeat (3) sync();
        chk("end_empty", tuple_valid, 1'b0);
        chk("end_drop", drop_count, 16'(exp_drop));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pkt_tuple_extractor.md
Name: pkt_tuple_extractor

Overview:
- Upstream feeder for the Bloom-filter firewall stage.
- Parses a 32-bit word stream of IPv4 packets and extracts the 5-tuple: src_ip, dst_ip, protocol, src_port and dst_port.
- Buffers tuples in a small FIFO and presents them on a valid/ready interface whose ready is driven by the firewall's ready_recv.
- Malformed packets are dropped and counted.

Parameters:
- DEPTH, 4, tuple FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  stream word valid.
- s_data  in  32  stream word; byte 0 of the packet is in bits [31:24].
- s_last  in  1  last word of the packet.
- s_ready  out  1  word accepted when s_valid && s_ready.
- tuple_valid  out  1  FIFO not empty.
- tuple_ready  in  1  consumer ready; wired to the firewall's ready_recv.
- ip_protocol  out  72  {src_ip[31:0], dst_ip[31:0], protocol[7:0]} of the FIFO head.
- src_port  out  16  FIFO head source port.
- dst_port  out  16  FIFO head destination port.
- drop_count  out  CNT_W  dropped-packet count, saturating.

Behaviour:
- Reset values: s_ready=1, tuple_valid=0, tuple fields=0, drop_count=0, FSM=W0, FIFO empty.
- A word is accepted when s_valid&&s_ready. Per-packet word index wi counts accepted words from 0.
- FSM states: W0, HDR, OPTS, L4, DRAIN.
- W0 (wi=0):
  - version=s_data[31:28], IHL=s_data[27:24].
  - If version!=4 or IHL<5: drop -> DRAIN (-> W0 if s_last).
  - Else latch IHL -> HDR.
- HDR (wi 1..4):
  - wi=2: latch protocol = s_data[23:16].
  - wi=3: latch src_ip. wi=4: latch dst_ip.
  - After wi=4: go to OPTS if IHL>5, else decide (see below).
- OPTS: discard IHL-5 words; decide after the last one.
- Decide at the last header word:
  - If protocol is 6 or 17 -> L4.
  - Otherwise push the tuple with ports=0 on that word -> DRAIN (-> W0 if s_last).
- L4: next word gives src_port=s_data[31:16], dst_port=s_data[15:0]. Push the tuple -> DRAIN (-> W0 if s_last).
- DRAIN: discard words until s_last, then -> W0.
- Truncation: s_last on any word before the tuple is complete -> drop, drop_count+1, -> W0.
- drop_count increments once per dropped packet and saturates at all-ones.
- Push cycle and stall:
  - A "push word" is the accepted word that completes a tuple.
  - s_ready=0 only when the FSM is positioned on a push word and the FIFO is full.
  - A pop in the same cycle does NOT relieve the stall; the decision uses the registered full flag.
- Output latency: tuple_valid rises the cycle after the push word is accepted (registered FIFO).
- Output hold: head fields are stable while tuple_valid && !tuple_ready. A pop happens on tuple_valid&&tuple_ready.
- Simultaneous push and pop with the FIFO not full: both occur; occupancy is unchanged.
- Reset mid-packet: FIFO is flushed, FSM -> W0. The next accepted word is treated as word 0; the upstream must restart at a packet boundary.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full and empty are derived from the MSB compare.

Optional Feature:
- Macro: HDR_CSUM_EN.
- Defined:
  - One's-complement 16-bit sum over all IHL header words (both halves), computed with end-around carry.
  - Sum checked on the last header word, including that word combinationally.
  - Result != 16'hFFFF -> drop, drop_count+1, no push (checked before the L4 push as well), -> DRAIN or W0.
- Undefined: no checksum logic; the header checksum field is ignored.

Test Plan:
- TCP, IHL=5: words 45000028, 00000000, 40060000, C0A80001, 0A000002, 1F900050 (s_last), tuple_ready=1 -> tuple_valid one cycle after word 5; ip_protocol=C0A800010A00000206, src_port=1F90, dst_port=0050; drop_count=0.
- ICMP (protocol=01), IHL=6, one option word, s_last on word 6 -> push on word 5 (the option) with ports=0000; word 6 is drained.
- Version 6 first word 60000000, 3-word packet -> no tuple, drop_count=1, next packet parsed normally. Truncated TCP ending at wi=3 -> drop_count=2.
- tuple_ready=0, DEPTH=4, five back-to-back TCP packets:
  - First four tuples buffered.
  - s_ready=0 on the fifth packet's L4 word.
  - After one pop, s_ready=1 the next cycle and the fifth tuple is pushed.
  - Output order is preserved.
- Assert rst_n=0 mid-HDR with two tuples buffered -> tuple_valid=0 immediately, drop_count=0, s_ready=1. A following full packet is extracted correctly.
- HDR_CSUM_EN defined: valid header checksum 0xB1E6 on example header 4500003C 1C464000 40060000 AC100A63 AC100A0C, sum=FFFF -> passes. Corrupted checksum -> drop_count+1, no tuple.
